exc_controller: RTL and testbench
=================================

Name: exc_controller

Overview:
Parametrised exception/interrupt controller for the single-cycle core. It replaces the single combinational ExtIRQ/NotAnInstr path with N latched IRQ channels that have per-channel enable, fixed priority, edge or level sensing, and a full request/ack/return handshake with the datapath. It sits beside the main decoder: it takes NotAnInstr, ExcAck and ERet, and drives Exc and EStatus to the datapath plus per-channel acks to devices.

Parameters:
N_IRQ, 4, number of external interrupt channels (1..8)
EDGE_MASK, 4'b0001, bit i=1: channel i edge-triggered (0->1 latched); bit i=0: level-sensitive

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
ExtIRQ  input  N_IRQ  external interrupt request lines, synchronous to clk
IrqEn  input  N_IRQ  per-channel enable (system register)
NotAnInstr  input  1  illegal-opcode flag from main decoder, current instruction
ExcAck  input  1  datapath has vectored to handler this cycle
ERet  input  1  ERET instruction executing
Exc  output  1  exception request to datapath
EStatus  output  4  cause code
ExtIAck  output  N_IRQ  one-cycle acknowledge to channel i
InService  output  1  handler active (FSM in SERVICE)
Pending  output  N_IRQ  pending register, for status readout
DoubleFault  output  1  sticky: illegal instruction inside handler

Behaviour:
- Reset (async, active-high): FSM=IDLE; pend, prev, cause_q, DoubleFault=0. While reset is high, Exc=0, EStatus=0, ExtIAck=0, InService=0, Pending=0.
- Cause codes: 4'h0 none; 4'h2 illegal instruction; 4'h8|i IRQ channel i; 4'hF double fault.
- Pending: edge channel sets pend[i] when ExtIRQ[i]&~prev[i] (prev = ExtIRQ registered). Level channel: pend[i] follows ExtIRQ[i] each cycle. The edge pend[i] clears on the cycle ExtIAck[i]=1. If a set and a clear coincide, the set wins.
- Candidate: lowest index i with pend[i]&IrqEn[i]. Disabled channels stay pending.
- FSM IDLE:
  - NotAnInstr=1 is a synchronous trap. Exc=1 and EStatus=2 combinationally in the same cycle, with priority over IRQs.
  - If ExcAck is also 1 that cycle: cause_q<=2, go to SERVICE.
  - Otherwise, if a candidate exists: cause_q<=8|i, sel_q<=i, go to REQ. IRQ latency is 1 cycle from pend to Exc.
- FSM REQ: Exc=1, EStatus=cause_q.
  - On ExcAck: ExtIAck[sel_q]=1 for that cycle only, go to SERVICE.
  - Channel disable or line drop in REQ does not withdraw the request.
  - NotAnInstr in REQ: EStatus=2 overrides. If ExcAck arrives, cause_q<=2 and no ExtIAck is issued; the IRQ stays pending.
- FSM SERVICE: InService=1, Exc=0, EStatus=cause_q. No nesting: IRQs only accumulate in pend.
  - NotAnInstr in SERVICE: DoubleFault<=1 (sticky until reset), cause_q<=F, no Exc.
  - ERet: go to IDLE next cycle. A waiting candidate gives Exc one cycle later.
- ERet outside SERVICE is ignored. ExcAck outside REQ is ignored unless NotAnInstr is high in IDLE.
- ExtIAck is at most one-hot and never asserted two consecutive cycles.

Decomposition:
- Package exc_pkg: cause-code localparams (EXC_NONE, EXC_ILLEGAL, EXC_IRQ_BASE, EXC_DOUBLE), FSM state enum (IDLE, REQ, SERVICE), ESTATUS_W=4.
- Sub-module irq_prio_enc, parametrised on N_IRQ: lowest-index priority encoder returning valid and index.
- Pending/edge logic and FSM stay in exc_controller.

Test Plan:
- Reset mid-REQ: pulse ExtIRQ[1], IrqEn=4'hF, assert reset while Exc=1. Required: Exc, EStatus, Pending, ExtIAck go to 0 immediately; after release, FSM is IDLE and no Exc.
- Priority: ExtIRQ=4'b0110 same cycle, IrqEn=4'hF. Required: next cycle Exc=1, EStatus=4'h9. Then ExcAck: ExtIAck=4'b0010 for one cycle, pend=4'b0100. ERet: IDLE, next cycle EStatus=4'hA, Exc=1.
- Illegal vs IRQ: pend[0]=1 and FSM in REQ, then NotAnInstr=1 with ExcAck=1. Required: EStatus=2, ExtIAck=0, SERVICE, pend[0] still 1.
- Masking: ExtIRQ[3] edge with IrqEn[3]=0. Required: Pending[3]=1, Exc=0 for 10 cycles. Set IrqEn[3]=1: Exc next cycle, EStatus=4'hB.
- Double fault: in SERVICE cause 8, NotAnInstr=1. Required: DoubleFault=1, EStatus=4'hF, Exc=0; DoubleFault stays 1 after ERet until reset.
- Edge re-pend: channel 0 edge arrives on the same cycle ExtIAck[0]=1. Required: pend[0]=1 afterwards; after ERet, a second Exc with EStatus=4'h8.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt controller: cause codes,
// controller state encoding and the cause-code width.
package exc_pkg;

  localparam int ESTATUS_W = 4;

  localparam logic [ESTATUS_W-1:0] EXC_NONE     = 4'h0;
  localparam logic [ESTATUS_W-1:0] EXC_ILLEGAL  = 4'h2;
  localparam logic [ESTATUS_W-1:0] EXC_IRQ_BASE = 4'h8;
  localparam logic [ESTATUS_W-1:0] EXC_DOUBLE   = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } exc_state_t;

endpackage

// File: rtl/exc_controller_if.sv
// Bundle between the core/devices and the exception controller. The slave
// side is the controller; the master side is the core/device environment.
interface exc_controller_if #(
  parameter int N_IRQ = 4
);
  import exc_pkg::*;

  logic [N_IRQ-1:0]     ExtIRQ;
  logic [N_IRQ-1:0]     IrqEn;
  logic                 NotAnInstr;
  logic                 ExcAck;
  logic                 ERet;
  logic                 Exc;
  logic [ESTATUS_W-1:0] EStatus;
  logic [N_IRQ-1:0]     ExtIAck;
  logic                 InService;
  logic [N_IRQ-1:0]     Pending;
  logic                 DoubleFault;

  modport slave (
    input  ExtIRQ, IrqEn, NotAnInstr, ExcAck, ERet,
    output Exc, EStatus, ExtIAck, InService, Pending, DoubleFault
  );

  modport master (
    output ExtIRQ, IrqEn, NotAnInstr, ExcAck, ERet,
    input  Exc, EStatus, ExtIAck, InService, Pending, DoubleFault
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index
// of the lowest-numbered one (lowest index wins).
module irq_prio_enc #(
  parameter int N_IRQ = 4,
  parameter int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/exc_controller.sv
// Exception/interrupt controller: latched IRQ channels with enable, fixed
// priority and edge/level sensing, plus the request/ack/return handshake.
module exc_controller
  import exc_pkg::*;
#(
  parameter int               N_IRQ     = 4,
  parameter logic [N_IRQ-1:0] EDGE_MASK = N_IRQ'(1)
) (
  input  logic              clk,
  input  logic              reset,
  exc_controller_if.slave   bus
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  exc_state_t           state_q, state_n;
  logic [N_IRQ-1:0]     pend_q, pend_n;
  logic [N_IRQ-1:0]     prev_q;
  logic [N_IRQ-1:0]     cand_req;
  logic [N_IRQ-1:0]     irq_ack;
  logic [ESTATUS_W-1:0] cause_q, cause_n;
  logic [ESTATUS_W-1:0] estatus_c;
  logic [IDX_W-1:0]     sel_q, sel_n;
  logic [IDX_W-1:0]     cand_idx;
  logic                 cand_vld;
  logic                 dfault_q, dfault_n;
  logic                 exc_c;
  logic                 ack_fire;

  assign cand_req = pend_q & bus.IrqEn;

  irq_prio_enc #(
    .N_IRQ (N_IRQ),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req   (cand_req),
    .valid (cand_vld),
    .idx   (cand_idx)
  );

  assign irq_ack = ack_fire ? (N_IRQ'(1) << sel_q) : '0;

  // Edge channels latch a rising edge until acknowledged; a new edge in the
  // ack cycle keeps the channel pending. Level channels mirror the line.
  always_comb begin
    pend_n = pend_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        pend_n[i] = (bus.ExtIRQ[i] & ~prev_q[i]) | (pend_q[i] & ~irq_ack[i]);
      end else begin
        pend_n[i] = bus.ExtIRQ[i];
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    cause_n   = cause_q;
    sel_n     = sel_q;
    dfault_n  = dfault_q;
    exc_c     = 1'b0;
    estatus_c = EXC_NONE;
    ack_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        // An illegal opcode traps in the same cycle, ahead of any IRQ.
        if (bus.NotAnInstr) begin
          exc_c     = 1'b1;
          estatus_c = EXC_ILLEGAL;
        end
        if (bus.NotAnInstr && bus.ExcAck) begin
          cause_n = EXC_ILLEGAL;
          state_n = SERVICE;
        end else if (cand_vld) begin
          cause_n = EXC_IRQ_BASE | ESTATUS_W'(cand_idx);
          sel_n   = cand_idx;
          state_n = REQ;
        end
      end
      REQ: begin
        exc_c     = 1'b1;
        estatus_c = bus.NotAnInstr ? EXC_ILLEGAL : cause_q;
        if (bus.ExcAck) begin
          state_n = SERVICE;
          // A trap taken over the IRQ leaves that channel pending.
          if (bus.NotAnInstr) begin
            cause_n = EXC_ILLEGAL;
          end else begin
            ack_fire = 1'b1;
          end
        end
      end
      SERVICE: begin
        estatus_c = cause_q;
        if (bus.NotAnInstr) begin
          dfault_n = 1'b1;
          cause_n  = EXC_DOUBLE;
        end
        if (bus.ERet) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      prev_q   <= '0;
      cause_q  <= EXC_NONE;
      sel_q    <= '0;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      pend_q   <= pend_n;
      prev_q   <= bus.ExtIRQ;
      cause_q  <= cause_n;
      sel_q    <= sel_n;
      dfault_q <= dfault_n;
    end
  end

  // Outputs are forced quiet while reset is held, including the
  // combinational trap path.
  assign bus.Exc         = exc_c & ~reset;
  assign bus.EStatus     = reset ? EXC_NONE : estatus_c;
  assign bus.ExtIAck     = reset ? '0 : irq_ack;
  assign bus.InService   = (state_q == SERVICE) & ~reset;
  assign bus.Pending     = reset ? '0 : pend_q;
  assign bus.DoubleFault = dfault_q & ~reset;

endmodule

// File: tb/tb_exc_controller.sv
// Directed bench for exc_controller: expected snapshots are queued as each
// step is driven and popped for comparison once the outputs settle.
module tb_exc_controller;

  logic clk;
  logic reset;

  exc_controller_if #(.N_IRQ(4)) bus ();

  exc_controller #(
    .N_IRQ     (4),
    .EDGE_MASK (4'b0001)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Snapshot order: Exc, EStatus, ExtIAck, InService, Pending, DoubleFault.
  task automatic ck(input string tag, input logic e, input logic [3:0] s,
                    input logic [3:0] a, input logic v, input logic [3:0] p,
                    input logic d);
    exp_t        x;
    exp_t        y;
    logic [14:0] obs;
    x.tag = tag;
    x.v   = {e, s, a, v, p, d};
    exp_q.push_back(x);
    #1;
    y   = exp_q.pop_front();
    obs = {bus.Exc, bus.EStatus, bus.ExtIAck, bus.InService, bus.Pending,
           bus.DoubleFault};
    n_checks++;
    assert (obs === y.v) else begin
      n_errors++;
      $error("FAIL %s: observed exc=%b est=%h ack=%b svc=%b pend=%b df=%b expected exc=%b est=%h ack=%b svc=%b pend=%b df=%b",
             y.tag, obs[14], obs[13:10], obs[9:6], obs[5], obs[4:1], obs[0],
             y.v[14], y.v[13:10], y.v[9:6], y.v[5], y.v[4:1], y.v[0]);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.ExtIRQ     = '0;
    bus.IrqEn      = '0;
    bus.NotAnInstr = 1'b1;
    bus.ExcAck     = 1'b0;
    bus.ERet       = 1'b0;
    ck("rst_trap_gated", 0, 4'h0, 4'b0000, 0, 4'b0000, 0);
    bus.NotAnInstr = 1'b0;
    step();
    reset = 1'b0;
    ck("idle_after_rst", 0, 4'h0, 4'b0000, 0, 4'b0000, 0);

    // Reset asserted while a request is outstanding
    bus.IrqEn  = 4'hF;
    bus.ExtIRQ = 4'b0010;
    ck("a_drive", 0, 4'h0, 4'b0000, 0, 4'b0000, 0);
    step();
    bus.ExtIRQ = 4'b0000;
    ck("a_pend", 0, 4'h0, 4'b0000, 0, 4'b0010, 0);
    step();
    ck("a_req", 1, 4'h9, 4'b0000, 0, 4'b0000, 0);
    reset = 1'b1;
    ck("a_rst_async", 0, 4'h0, 4'b0000, 0, 4'b0000, 0);
    step();
    reset = 1'b0;
    ck("a_released", 0, 4'h0, 4'b0000, 0, 4'b0000, 0);
    step();
    ck("a_no_exc", 0, 4'h0, 4'b0000, 0, 4'b0000, 0);

    // Two channels at once: lowest index first, then the other after ERet
    bus.ExtIRQ = 4'b0110;
    ck("b_drive", 0, 4'h0, 4'b0000, 0, 4'b0000, 0);
    step();
    bus.ExtIRQ = 4'b0100;
    ck("b_pend", 0, 4'h0, 4'b0000, 0, 4'b0110, 0);
    step();
    ck("b_req", 1, 4'h9, 4'b0000, 0, 4'b0100, 0);
    bus.ExcAck = 1'b1;
    ck("b_ack", 1, 4'h9, 4'b0010, 0, 4'b0100, 0);
    step();
    bus.ExcAck = 1'b0;
    ck("b_svc", 0, 4'h9, 4'b0000, 1, 4'b0100, 0);
    bus.ERet = 1'b1;
    ck("b_eret", 0, 4'h9, 4'b0000, 1, 4'b0100, 0);
    step();
    bus.ERet = 1'b0;
    ck("b_idle", 0, 4'h0, 4'b0000, 0, 4'b0100, 0);
    step();
    ck("b_req2", 1, 4'hA, 4'b0000, 0, 4'b0100, 0);
    bus.ExcAck = 1'b1;
    bus.ExtIRQ = 4'b0000;
    ck("b_ack2", 1, 4'hA, 4'b0100, 0, 4'b0100, 0);
    step();
    bus.ExcAck = 1'b0;
    ck("b_svc2", 0, 4'hA, 4'b0000, 1, 4'b0000, 0);
    bus.ERet = 1'b1;
    step();
    bus.ERet = 1'b0;
    ck("b_done", 0, 4'h0, 4'b0000, 0, 4'b0000, 0);

    // Illegal instruction taken over a pending IRQ in REQ
    bus.ExtIRQ = 4'b0001;
    ck("c_drive", 0, 4'h0, 4'b0000, 0, 4'b0000, 0);
    step();
    bus.ExtIRQ = 4'b0000;
    ck("c_pend", 0, 4'h0, 4'b0000, 0, 4'b0001, 0);
    step();
    ck("c_req", 1, 4'h8, 4'b0000, 0, 4'b0001, 0);
    bus.NotAnInstr = 1'b1;
    bus.ExcAck     = 1'b1;
    ck("c_ill_ack", 1, 4'h2, 4'b0000, 0, 4'b0001, 0);
    step();
    bus.NotAnInstr = 1'b0;
    bus.ExcAck     = 1'b0;
    ck("c_svc", 0, 4'h2, 4'b0000, 1, 4'b0001, 0);
    bus.ERet = 1'b1;
    step();
    bus.ERet = 1'b0;
    ck("c_idle", 0, 4'h0, 4'b0000, 0, 4'b0001, 0);
    step();
    ck("c_req2", 1, 4'h8, 4'b0000, 0, 4'b0001, 0);

    // New edge on channel 0 in the very cycle it is acknowledged
    bus.ExcAck = 1'b1;
    bus.ExtIRQ = 4'b0001;
    ck("e_ack_edge", 1, 4'h8, 4'b0001, 0, 4'b0001, 0);
    step();
    bus.ExcAck = 1'b0;
    bus.ExtIRQ = 4'b0000;
    ck("e_repend", 0, 4'h8, 4'b0000, 1, 4'b0001, 0);

    // Illegal instruction inside the handler
    bus.NotAnInstr = 1'b1;
    ck("d_trap_in_svc", 0, 4'h8, 4'b0000, 1, 4'b0001, 0);
    step();
    bus.NotAnInstr = 1'b0;
    ck("d_dfault", 0, 4'hF, 4'b0000, 1, 4'b0001, 1);
    bus.ERet = 1'b1;
    step();
    bus.ERet = 1'b0;
    ck("d_idle", 0, 4'h0, 4'b0000, 0, 4'b0001, 1);
    step();
    ck("e_req2", 1, 4'h8, 4'b0000, 0, 4'b0001, 1);
    bus.ExcAck = 1'b1;
    ck("e_ack2", 1, 4'h8, 4'b0001, 0, 4'b0001, 1);
    step();
    bus.ExcAck = 1'b0;
    ck("e_svc2", 0, 4'h8, 4'b0000, 1, 4'b0000, 1);
    bus.ERet = 1'b1;
    step();
    bus.ERet = 1'b0;
    ck("d_sticky", 0, 4'h0, 4'b0000, 0, 4'b0000, 1);

    // Disabled channel stays pending without raising Exc
    bus.IrqEn  = 4'b0111;
    bus.ExtIRQ = 4'b1000;
    ck("m_drive", 0, 4'h0, 4'b0000, 0, 4'b0000, 1);
    step();
    for (int i = 0; i < 10; i++) begin
      ck("m_masked", 0, 4'h0, 4'b0000, 0, 4'b1000, 1);
      step();
    end
    bus.IrqEn = 4'hF;
    ck("m_enable", 0, 4'h0, 4'b0000, 0, 4'b1000, 1);
    step();
    ck("m_req", 1, 4'hB, 4'b0000, 0, 4'b1000, 1);
    bus.ExcAck = 1'b1;
    bus.ExtIRQ = 4'b0000;
    ck("m_ack", 1, 4'hB, 4'b1000, 0, 4'b1000, 1);
    step();
    bus.ExcAck = 1'b0;
    ck("m_svc", 0, 4'hB, 4'b0000, 1, 4'b0000, 1);
    bus.ERet = 1'b1;
    step();
    bus.ERet = 1'b0;

    // Trap from IDLE, stray ack ignored
    bus.NotAnInstr = 1'b1;
    ck("t_trap_comb", 1, 4'h2, 4'b0000, 0, 4'b0000, 1);
    step();
    bus.ExcAck = 1'b1;
    ck("t_trap_ack", 1, 4'h2, 4'b0000, 0, 4'b0000, 1);
    step();
    bus.NotAnInstr = 1'b0;
    bus.ExcAck     = 1'b0;
    ck("t_svc", 0, 4'h2, 4'b0000, 1, 4'b0000, 1);
    bus.ERet = 1'b1;
    step();
    bus.ERet = 1'b0;
    ck("t_idle", 0, 4'h0, 4'b0000, 0, 4'b0000, 1);
    bus.ExcAck = 1'b1;
    bus.ERet   = 1'b1;
    step();
    bus.ExcAck = 1'b0;
    bus.ERet   = 1'b0;
    ck("t_stray", 0, 4'h0, 4'b0000, 0, 4'b0000, 1);

    // Only reset clears the sticky double-fault flag
    reset = 1'b1;
    ck("f_rst", 0, 4'h0, 4'b0000, 0, 4'b0000, 0);
    step();
    reset = 1'b0;
    ck("f_df_clear", 0, 4'h0, 4'b0000, 0, 4'b0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
